// File: rtl/debug_pkg.sv
// Shared types and encodings for the host debug responder.
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_RF   = 3'd1,
        DM_ADDR = 3'd2,
        DM_CAP  = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_DM  = 2'd1;
    localparam logic [1:0] SEL_CSR = 2'd2;
    localparam logic [1:0] SEL_RSV = 2'd3;

    localparam logic [7:0] CSR_PC  = 8'd0;
    localparam logic [7:0] CSR_CYC = 8'd1;

    localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/debug_runctl.sv
// Halt/step run control: core clock enable, step rising-edge pulse and enabled-cycle counter.
module debug_runctl (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        step,
    output logic        cpu_en,
    output logic [31:0] cyc_cnt
);

    logic step_q;

    // A step only matters while halted, and only its rising edge grants one enable cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q  <= 1'b0;
            cpu_en  <= 1'b0;
            cyc_cnt <= 32'd0;
        end else begin
            step_q <= step;
            cpu_en <= !halt || (step && !step_q);
            if (cpu_en) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/debug_responder.sv
// Host debug request responder: reads RF, DM or CSRs and returns one response per request.
module debug_responder
    import debug_pkg::*;
#(
    parameter int unsigned DM_AW = 8,
    parameter int unsigned RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic [7:0]       req_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [31:0]      resp_pc,
    output logic             resp_err,
    output logic [RF_AW-1:0] rf_addr,
    input  logic [31:0]      rf_data,
    output logic [DM_AW-1:0] dm_addr,
    output logic             dm_rd_en,
    input  logic [31:0]      dm_data,
    input  logic [31:0]      core_pc,
    input  logic             halt,
    input  logic             step,
    output logic             cpu_en
);

    state_t           state, state_n;
    logic [1:0]       sel_q, sel_n;
    logic [7:0]       addr_q, addr_n;
    logic [31:0]      pc_n, data_n;
    logic             err_n;
    logic [RF_AW-1:0] rf_addr_n;
    logic [DM_AW-1:0] dm_addr_n;
    logic [31:0]      cyc_cnt;
    logic             req_err_c;

    debug_runctl u_runctl (
        .clk     (clk),
        .rst     (rst),
        .halt    (halt),
        .step    (step),
        .cpu_en  (cpu_en),
        .cyc_cnt (cyc_cnt)
    );

    // Requests that are answered immediately with an error and no target access.
    always_comb begin
        req_err_c = 1'b0;
        if (req_sel == SEL_RSV) begin
            req_err_c = 1'b1;
        end else if (req_sel == SEL_RF) begin
            req_err_c = ((req_addr >> RF_AW) != 8'd0);
        end else if (req_sel == SEL_CSR) begin
            req_err_c = (req_addr > CSR_CYC);
        end
    end

    always_comb begin
        state_n   = state;
        sel_n     = sel_q;
        addr_n    = addr_q;
        pc_n      = resp_pc;
        data_n    = resp_data;
        err_n     = resp_err;
        rf_addr_n = rf_addr;
        dm_addr_n = dm_addr;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    sel_n  = req_sel;
                    addr_n = req_addr;
                    pc_n   = core_pc;
                    data_n = 32'd0;
                    err_n  = req_err_c;
                    if (req_err_c) begin
                        state_n = RESP;
                    end else if (req_sel == SEL_DM) begin
                        dm_addr_n = DM_AW'(req_addr);
                        state_n   = DM_ADDR;
                    end else begin
                        // CSR reads share RD_RF timing but leave the RF port untouched.
                        if (req_sel == SEL_RF) begin
                            rf_addr_n = RF_AW'(req_addr);
                        end
                        state_n = RD_RF;
                    end
                end
            end
            RD_RF: begin
                if (sel_q == SEL_RF) begin
                    data_n = (addr_q == 8'd0) ? 32'd0 : rf_data;
                end else begin
                    data_n = (addr_q == CSR_PC) ? resp_pc : cyc_cnt;
                end
                state_n = RESP;
            end
            DM_ADDR: begin
                state_n = DM_CAP;
            end
            DM_CAP: begin
                data_n  = dm_data;
                state_n = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= SEL_RF;
            addr_q     <= 8'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_pc    <= 32'd0;
            resp_err   <= 1'b0;
            dm_rd_en   <= 1'b0;
            rf_addr    <= '0;
            dm_addr    <= '0;
        end else begin
            state      <= state_n;
            sel_q      <= sel_n;
            addr_q     <= addr_n;
            req_ready  <= (state_n == IDLE);
            resp_valid <= (state_n == RESP);
            resp_data  <= data_n;
            resp_pc    <= pc_n;
            resp_err   <= err_n;
            dm_rd_en   <= (state_n == DM_ADDR);
            rf_addr    <= rf_addr_n;
            dm_addr    <= dm_addr_n;
        end
    end

endmodule

// File: tb/tb_debug_responder.sv
// Directed bench for debug_responder: request paths, error decode, hold behaviour, run control, reset.
module tb_debug_responder;
    import debug_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_sel;
    logic [7:0]  req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [31:0] resp_pc;
    logic        resp_err;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [7:0]  dm_addr;
    logic        dm_rd_en;
    logic [31:0] dm_data = 32'd0;
    logic [31:0] core_pc;
    logic        halt;
    logic        step;
    logic        cpu_en;

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  last_rf = 5'd0;
    int          ones;

    always #5 clk = ~clk;

    // Data memory: data appears the cycle after a read strobe, zero otherwise.
    always @(posedge clk) begin
        if (dm_rd_en) dm_data <= (dm_addr == 8'h10) ? 32'hDEADBEEF : {24'h0, dm_addr};
        else          dm_data <= 32'h0;
    end

    debug_responder #(.DM_AW(8), .RF_AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_pc    (resp_pc),
        .resp_err   (resp_err),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .dm_addr    (dm_addr),
        .dm_rd_en   (dm_rd_en),
        .dm_data    (dm_data),
        .core_pc    (core_pc),
        .halt       (halt),
        .step       (step),
        .cpu_en     (cpu_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full request: accept, latency, optional stall with stability checks, handshake.
    task automatic do_req(input string tag, input logic [1:0] sel, input logic [7:0] addr,
                          input logic [31:0] pc, input int exp_lat, input logic [31:0] exp_data,
                          input logic exp_err, input int hold);
        int lat;
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_sel   = sel;
        req_addr  = addr;
        core_pc   = pc;
        cyc();
        req_valid = 1'b0;
        req_sel   = SEL_RSV;
        req_addr  = 8'hFF;
        core_pc   = ~pc;
        if (sel == SEL_RF && exp_lat == 2) begin
            check({tag, ".rf_addr"}, 32'(rf_addr), 32'(addr[4:0]));
            last_rf = addr[4:0];
        end
        if (sel == SEL_CSR && exp_lat == 2)
            check({tag, ".rf_addr_hold"}, 32'(rf_addr), 32'(last_rf));
        if (sel == SEL_DM) begin
            check({tag, ".dm_rd_en"}, 32'(dm_rd_en), 32'd1);
            check({tag, ".dm_addr"}, 32'(dm_addr), 32'(addr));
        end
        lat = 1;
        while (!resp_valid && lat < 8) begin
            cyc();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".data"}, resp_data, exp_data);
        check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        check({tag, ".pc"}, resp_pc, pc);
        if (sel == SEL_DM) check({tag, ".dm_rd_en_off"}, 32'(dm_rd_en), 32'd0);
        for (int i = 0; i < hold; i++) begin
            cyc();
            check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".hold_data"}, resp_data, exp_data);
            check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        check({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ".post_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; step = 1'b0;
        req_valid = 1'b0; req_sel = 2'd0; req_addr = 8'd0;
        resp_ready = 1'b0; rf_data = 32'd0; core_pc = 32'd0;
        repeat (3) cyc();
        check("rst.cpu_en", 32'(cpu_en), 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_data", resp_data, 32'd0);
        check("rst.resp_pc", resp_pc, 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.dm_rd_en", 32'(dm_rd_en), 32'd0);
        check("rst.rf_addr", 32'(rf_addr), 32'd0);
        check("rst.dm_addr", 32'(dm_addr), 32'd0);
        halt = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        check("halted.cpu_en", 32'(cpu_en), 32'd0);

        // Target paths and error decode
        do_req("csr_cyc0", SEL_CSR, 8'd1, 32'h0000_0100, 2, 32'd0, 1'b0, 0);
        rf_data = 32'h0000_0015;
        do_req("rf6", SEL_RF, 8'd6, 32'h1000_0004, 2, 32'h15, 1'b0, 0);
        do_req("dm10", SEL_DM, 8'h10, 32'h2000_0008, 3, 32'hDEADBEEF, 1'b0, 4);
        do_req("dm33", SEL_DM, 8'h33, 32'h2000_000C, 3, 32'h33, 1'b0, 0);
        do_req("sel3", SEL_RSV, 8'h01, 32'h3000_0000, 1, 32'd0, 1'b1, 0);
        rf_data = 32'h0000_0055;
        do_req("rf20", SEL_RF, 8'h20, 32'h3000_0004, 1, 32'd0, 1'b1, 0);
        do_req("rf0", SEL_RF, 8'h00, 32'h3000_0008, 2, 32'd0, 1'b0, 0);
        do_req("rf31", SEL_RF, 8'h1F, 32'h3000_000C, 2, 32'h55, 1'b0, 0);
        do_req("csr2", SEL_CSR, 8'd2, 32'h3000_0010, 1, 32'd0, 1'b1, 2);
        do_req("csr_pc", SEL_CSR, CSR_PC, 32'hCAFE_0010, 2, 32'hCAFE_0010, 1'b0, 0);

        // Halted: no enable, counter frozen
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("halt5.cpu_en", 32'(cpu_en), 32'd0);
        end
        do_req("csr_cyc_frozen", SEL_CSR, CSR_CYC, 32'h4000_0000, 2, 32'd0, 1'b0, 0);

        // Step held three cycles grants a single enable cycle
        step = 1'b1;
        ones = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            ones += int'(cpu_en);
            if (i == 2) step = 1'b0;
        end
        check("step.enable_cycles", 32'(ones), 32'd1);
        do_req("csr_cyc_step", SEL_CSR, CSR_CYC, 32'h4000_0004, 2, 32'd1, 1'b0, 0);

        // Running for four cycles; a step pulse meanwhile adds nothing
        halt = 1'b0;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            ones += int'(cpu_en);
            if (i == 1) step = 1'b1;
            if (i == 2) step = 1'b0;
        end
        halt = 1'b1;
        cyc();
        check("run.cpu_en_off", 32'(cpu_en), 32'd0);
        check("run.enable_cycles", 32'(ones), 32'd4);
        cyc();
        check("run.cpu_en_stays_off", 32'(cpu_en), 32'd0);
        do_req("csr_cyc_run", SEL_CSR, CSR_CYC, 32'h4000_0008, 2, 32'd5, 1'b0, 0);

        // Reset while capturing DM data abandons the transaction
        check("rstmid.req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_sel = SEL_DM; req_addr = 8'h10; core_pc = 32'h5000_0000;
        cyc();
        req_valid = 1'b0;
        cyc();
        check("rstmid.dm_rd_en_cap", 32'(dm_rd_en), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rstmid.resp_valid", 32'(resp_valid), 32'd0);
        check("rstmid.req_ready", 32'(req_ready), 32'd1);
        cyc();
        check("rstmid.no_resp", 32'(resp_valid), 32'd0);
        rf_data = 32'h0000_0015;
        last_rf = 5'd0;
        do_req("rf6_post_rst", SEL_RF, 8'd6, 32'h5000_0004, 2, 32'h15, 1'b0, 0);
        do_req("csr_cyc_post_rst", SEL_CSR, CSR_CYC, 32'h5000_0008, 2, 32'd0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_responder.md
DEBUG_RESPONDER -- requirements
Module: debug_responder

Interface
REQ-001 Parameter DM_AW, default 8, SHALL set the data-memory debug read address width.
REQ-002 Parameter RF_AW, default 5, SHALL set the register-file address width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req_valid  input  1  SHALL mark a host debug request.
REQ-006 req_ready  output  1  SHALL indicate that a request is accepted this cycle.
REQ-007 req_sel  input  2  SHALL select the target: 0=RF, 1=DM, 2=CSR, 3=reserved.
REQ-008 req_addr  input  8  SHALL carry the word address within the selected target.
REQ-009 resp_valid, resp_ready SHALL form the handshake for resp_data[31:0] (output), resp_pc[31:0] (output) and resp_err (output, 1 bit).
REQ-010 rf_addr  output  RF_AW  SHALL drive the RF debug read port; rf_data  input  32  SHALL be its combinational result.
REQ-011 dm_addr  output  DM_AW  and dm_rd_en  output  1  SHALL drive the DM debug read port; dm_data  input  32  SHALL be valid one cycle after dm_rd_en.
REQ-012 core_pc  input  32  SHALL be the current core PC.
REQ-013 halt  input  1  (level) and step  input  1  (pulse) SHALL be run controls; cpu_en  output  1  SHALL be the core clock enable.

Function
REQ-014 States SHALL be IDLE, RD_RF, DM_ADDR, DM_CAP and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 Acceptance at cycle T (req_valid&&req_ready) SHALL latch req_sel, req_addr and core_pc (the latter into resp_pc).
REQ-016 RF path: IDLE->RD_RF->RESP; RD_RF SHALL drive rf_addr=addr[4:0] and capture rf_data; resp_valid SHALL rise at T+2.
REQ-017 RF address 0 SHALL return 0 regardless of rf_data.
REQ-018 DM path: IDLE->DM_ADDR (dm_rd_en=1)->DM_CAP (capture dm_data)->RESP; resp_valid SHALL rise at T+3.
REQ-019 CSR path: addr 0 SHALL return the latched PC and addr 1 SHALL return cyc_cnt; flow SHALL be IDLE->RD_RF->RESP with no RF port activity and resp_valid at T+2.
REQ-020 Each of the following SHALL go IDLE->RESP with resp_data=0, resp_err=1 and resp_valid at T+1: sel=3; RF with addr[7:5]!=0; CSR with addr>1.
REQ-021 In RESP, resp_valid, resp_data, resp_pc and resp_err SHALL hold stable until resp_ready; the handshake cycle SHALL return to IDLE, so req_ready is 1 the next cycle.
REQ-022 dm_rd_en SHALL be 0 outside DM_ADDR; rf_addr and dm_addr SHALL hold their last values when unused.
REQ-023 cpu_en SHALL equal !halt, except that with halt=1 a step pulse SHALL give cpu_en=1 for exactly the next cycle.
REQ-024 A step held high several cycles SHALL yield one enable cycle, because detection is on the rising edge.
REQ-025 Step while halt=0 SHALL be ignored.
REQ-026 cyc_cnt (32 bits) SHALL increment on every cycle with cpu_en=1 and wrap from 0xFFFFFFFF to 0.

Reset
REQ-027 Reset SHALL force: state=IDLE, req_ready=1 on the first post-reset cycle, resp_valid=0, resp_data=0, resp_pc=0, resp_err=0, dm_rd_en=0, rf_addr=0, dm_addr=0, cyc_cnt=0 and the step edge detector cleared.
REQ-028 Reset during any non-IDLE state SHALL abandon the transaction with no response.
REQ-029 During reset cpu_en SHALL be 0.

Structure
REQ-030 Package debug_pkg SHALL hold the state enum, the req_sel encodings (SEL_RF, SEL_DM, SEL_CSR) and the CSR addresses (CSR_PC=0, CSR_CYC=1).
REQ-031 Sub-module debug_runctl SHALL contain the halt/step logic, the step edge detector and cyc_cnt; the request FSM SHALL stay in debug_responder.

Verification
REQ-032 RF read: rf_data=0x0000_0015 with addr 6 requested at T -> resp_valid at T+2, resp_data=0x15, resp_err=0, and rf_addr=6 during RD_RF.
REQ-033 DM read: addr 0x10, with dm_data=0xDEADBEEF the cycle after dm_rd_en -> resp_valid at T+3, data=0xDEADBEEF; resp_ready held low 4 cycles -> outputs stable and req_ready=0.
REQ-034 Errors: sel=3 -> err=1, data=0 at T+1; RF addr 0x20 -> err=1; RF addr 0 with rf_data=0x55 -> data=0.
REQ-035 Run control: halt=1 for 5 cycles -> cpu_en=0 and cyc_cnt frozen; step high 3 cycles -> exactly 1 cpu_en cycle and cyc_cnt+1; CSR addr 1 read -> the matching count.
REQ-036 Reset mid-DM_CAP -> next cycle resp_valid=0, req_ready=1; a new RF request then completes normally at T+2.
